// File: rtl/lpf_uart_pkg.sv
// lpf_uart_pkg: shared types and constants for the FIR-output UART transmitter
package lpf_uart_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {IDLE, SYNC, HI, LO} state_t;
    typedef enum logic [1:0] {START, DATA, STOP} phase_t;

    function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [31:0] s);
        return s > 32'sd32767 ? 16'h7FFF : s < -32'sd32768 ? 16'h8000 : s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/lpf_uart_tx_sample_fifo.sv
// sample_fifo: synchronous FIFO with registered read data and occupancy count
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Push,
    input  logic                     Pop,
    input  logic [WIDTH-1:0]         Wdata,
    output logic [WIDTH-1:0]         Rdata,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign Empty = Level == '0;
    assign Full = Level == (AW+1)'(DEPTH);
    assign do_pop = Pop && !Empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is still taken
    assign do_push = Push && (!Full || do_pop);

    always_ff @(posedge Clk)
        if (do_push) mem[wr_ptr] <= Wdata;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Level <= '0;
            Rdata <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                Rdata <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            Level <= Level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/lpf_uart_tx.sv
// lpf_uart_tx: saturate FIR samples, queue them, send each as two 8N1 bytes (high first)
// Define FRAME_SYNC_EN to prefix every frame with sync byte A5.
module lpf_uart_tx
    import lpf_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int SHIFT        = 0
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic signed [31:0]            Yin,
    input  logic                          Sample_en,
    output logic                          Tx,
    output logic                          Busy,
    output logic                          Ovf,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_TOP = CW'(CLKS_PER_BIT - 1);
`ifdef FRAME_SYNC_EN
    localparam state_t FIRST = SYNC;
`else
    localparam state_t FIRST = HI;
`endif

    state_t state;
    phase_t phase;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [SAMPLE_W-1:0] hold, rd_data, sat;
    logic [7:0] cur_byte;
    logic fetched, full, empty, pop;

    assign sat = saturate(Yin >>> SHIFT);
    assign cur_byte = state == SYNC ? SYNC_BYTE : state == HI ? hold[15:8] : hold[7:0];
    // Pop one cycle early so the registered FIFO data is ready exactly at the frame boundary
    assign pop = !fetched && !empty &&
                 (state == IDLE || (state == LO && phase == STOP && cnt == CW'(1)));

    sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .Push  (Sample_en),
        .Pop   (pop),
        .Wdata (sat),
        .Rdata (rd_data),
        .Full  (full),
        .Empty (empty),
        .Level (Fifo_level)
    );

    always_ff @(posedge Clk) begin
        if (Rst) Ovf <= 1'b0;
        else if (Sample_en && full && !pop) Ovf <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            phase <= START;
            cnt <= '0;
            bit_idx <= '0;
            hold <= '0;
            fetched <= 1'b0;
            Tx <= 1'b1;
            Busy <= 1'b0;
        end else if (state == IDLE) begin
            if (fetched) begin
                hold <= rd_data;
                fetched <= 1'b0;
                Busy <= 1'b1;
                Tx <= 1'b0;
                phase <= START;
                cnt <= CNT_TOP;
                state <= FIRST;
            end else if (pop) fetched <= 1'b1;
        end else begin
            if (pop) fetched <= 1'b1;
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
                cnt <= CNT_TOP;
                if (phase == START) begin
                    phase <= DATA;
                    bit_idx <= '0;
                    Tx <= cur_byte[0];
                end else if (phase == DATA) begin
                    phase <= bit_idx == 3'd7 ? STOP : DATA;
                    Tx <= bit_idx == 3'd7 ? 1'b1 : cur_byte[bit_idx + 3'd1];
                    bit_idx <= bit_idx + 3'd1;
                end else if (state != LO) begin
                    state <= state == SYNC ? HI : LO;
                    phase <= START;
                    Tx <= 1'b0;
                end else if (fetched) begin
                    hold <= rd_data;
                    fetched <= 1'b0;
                    state <= FIRST;
                    phase <= START;
                    Tx <= 1'b0;
                end else begin
                    state <= IDLE;
                    Busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lpf_uart_tx.sv
// tb_lpf_uart_tx: two DUTs (SHIFT 0 and 4) on shared stimulus, checked by a UART line decoder
module tb_lpf_uart_tx;

    localparam int P = 4;
`ifdef FRAME_SYNC_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int FRAME = NB * 10 * P;

    logic Clk = 1'b0;
    logic Rst, Sample_en;
    logic signed [31:0] Yin;
    logic [1:0] tx, busy, ovf;
    logic [3:0] lvl0, lvl1;
    int cyc = 0;
    int n_tests = 0, n_fail = 0;
    int rd[2] = '{0, 0};
    int ph[2] = '{-1, -1};
    int busy_cnt[2] = '{0, 0};
    int ferr[2] = '{0, 0};
    int scyc;
    logic [7:0] sh[2];
    logic [7:0] rx0[$], rx1[$];
    int fall0[$], fall1[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    lpf_uart_tx #(.CLKS_PER_BIT(P), .FIFO_DEPTH(8), .SHIFT(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Yin(Yin), .Sample_en(Sample_en),
        .Tx(tx[0]), .Busy(busy[0]), .Ovf(ovf[0]), .Fifo_level(lvl0));

    lpf_uart_tx #(.CLKS_PER_BIT(P), .FIFO_DEPTH(8), .SHIFT(4)) dut1 (
        .Clk(Clk), .Rst(Rst), .Yin(Yin), .Sample_en(Sample_en),
        .Tx(tx[1]), .Busy(busy[1]), .Ovf(ovf[1]), .Fifo_level(lvl1));

    // Line decoder: finds start bits and samples every bit mid-period
    always @(negedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (busy[k]) busy_cnt[k]++;
            if (Rst) ph[k] = -1;
            else if (ph[k] < 0) begin
                if (!tx[k]) begin
                    ph[k] = 0;
                    if (k == 0) fall0.push_back(cyc); else fall1.push_back(cyc);
                end
            end else begin
                ph[k]++;
                if (ph[k] == P / 2 && tx[k]) ferr[k]++;
                if (ph[k] % P == P / 2 && ph[k] > P && ph[k] < 9 * P) sh[k] = {tx[k], sh[k][7:1]};
                if (ph[k] == 9 * P + P / 2) begin
                    if (!tx[k]) ferr[k]++;
                    if (k == 0) rx0.push_back(sh[k]); else rx1.push_back(sh[k]);
                    ph[k] = -1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input int y, input int s);
        longint v;
        v = longint'(y) >>> s;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [7:0] got(input int k, input int i);
        return k == 0 ? rx0[i] : rx1[i];
    endfunction

    task automatic expect_bytes(input int y, input int n);
        logic [15:0] s;
        logic [7:0] e[3];
        for (int k = 0; k < 2; k++) begin
            s = model(y, k * 4);
            e[0] = 8'hA5;
            e[NB-2] = s[15:8];
            e[NB-1] = s[7:0];
            for (int j = 0; j < n; j++) begin
                chk($sformatf("dut%0d y=%0d byte%0d", k, y, j), 32'(got(k, rd[k])), 32'(e[j]));
                rd[k]++;
            end
        end
    endtask

    task automatic wait_bytes(input int n, input int limit);
        int t = 0;
        while ((rx0.size() < rd[0] + n || rx1.size() < rd[1] + n) && t < limit) begin
            @(negedge Clk);
            t++;
        end
        chk("wait_bytes", 32'(t < limit), 32'd1);
    endtask

    task automatic strobe(input int y);
        Yin = y;
        Sample_en = 1'b1;
        scyc = cyc + 1;
        @(negedge Clk);
        Sample_en = 1'b0;
    endtask

    task automatic one_sample(input int y);
        strobe(y);
        wait_bytes(NB, FRAME + 50);
        expect_bytes(y, NB);
    endtask

    int ys[10];
    int f, b0, b1, y, t;

    initial begin
        Rst = 1'b1;
        Sample_en = 1'b1;
        Yin = 32'h1234;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        Sample_en = 1'b0;
        @(negedge Clk);
        chk("rst tx", 32'(tx), 32'h3);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst ovf", 32'(ovf), 32'h0);
        chk("rst lvl0", 32'(lvl0), 32'h0);
        chk("rst lvl1", 32'(lvl1), 32'h0);
        repeat (20) @(negedge Clk);
        chk("rst no frame", 32'(rx0.size() + rx1.size() + fall0.size()), 32'h0);

        b0 = busy_cnt[0];
        b1 = busy_cnt[1];
        f = fall0.size();
        one_sample(32'h00001234);
        chk("latency0", 32'(fall0[f] - scyc), 32'd2);
        chk("latency1", 32'(fall1[f] - scyc), 32'd2);
        repeat (10) @(negedge Clk);
        chk("busy len0", 32'(busy_cnt[0] - b0), 32'(FRAME));
        chk("busy len1", 32'(busy_cnt[1] - b1), 32'(FRAME));
        chk("busy idle", 32'(busy), 32'h0);

        one_sample(32'h00012345);
        one_sample(-100000);
        one_sample(32'h00012340);
        one_sample(32'h00007FFF);
        one_sample(-32768);
        one_sample(-32769);

        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0: y = int'($urandom);
                1: y = int'($urandom_range(0, 1 << 21)) - (1 << 20);
                default: y = int'($urandom_range(0, 600000)) - 300000;
            endcase
            one_sample(y);
        end

        f = fall0.size();
        for (int i = 0; i < 10; i++) begin
            ys[i] = int'($urandom_range(0, 1 << 21)) - (1 << 20);
            strobe(ys[i]);
        end
        chk("full lvl0", 32'(lvl0), 32'd8);
        chk("full lvl1", 32'(lvl1), 32'd8);
        chk("ovf set", 32'(ovf), 32'h3);
        wait_bytes(9 * NB, 9 * FRAME + 100);
        for (int i = 0; i < 9; i++) expect_bytes(ys[i], NB);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("gap0 %0d", i), 32'(fall0[f + i * NB] - fall0[f + (i - 1) * NB]), 32'(FRAME / NB * NB));
            chk($sformatf("gap1 %0d", i), 32'(fall1[f + i * NB] - fall1[f + (i - 1) * NB]), 32'(FRAME / NB * NB));
        end
        repeat (3 * FRAME) @(negedge Clk);
        chk("dropped 10th", 32'(rx0.size() - rd[0]), 32'h0);
        chk("ovf sticky", 32'(ovf), 32'h3);
        chk("drained lvl", 32'({lvl1, lvl0}), 32'h0);

        f = fall0.size();
        ys[0] = int'($urandom_range(0, 60000)) - 30000;
        strobe(ys[0]);
        strobe(int'($urandom));
        strobe(int'($urandom));
        t = 0;
        while (fall0.size() <= f && t < 50) begin
            @(negedge Clk);
            t++;
        end
        chk("abort start", 32'(t < 50), 32'd1);
        repeat ((NB - 1) * 10 * P + 14) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk("abort tx", 32'(tx), 32'h3);
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort lvl", 32'({lvl1, lvl0}), 32'h0);
        chk("abort ovf", 32'(ovf), 32'h0);
        Rst = 1'b0;
        repeat (4 * FRAME) @(negedge Clk);
        chk("abort cnt0", 32'(rx0.size() - rd[0]), 32'(NB - 1));
        chk("abort cnt1", 32'(rx1.size() - rd[1]), 32'(NB - 1));
        expect_bytes(ys[0], NB - 1);
        chk("abort idle", 32'(tx), 32'h3);

        one_sample(int'($urandom));
        chk("framing", 32'(ferr[0] + ferr[1]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
